// File: rtl/a2d_arb_pkg.sv
// Shared types and defaults for the A2D arbiter and its round-robin picker.
package a2d_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF    = 3;
  localparam int TMO_CYCLES_DEF = 4095;
  localparam int RSLT_W         = 12;

  typedef logic [RSLT_W-1:0] rslt_t;

  // Width of an index into NUM_REQ requesters (at least one bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/a2d_arb_rr_pick.sv
// Combinational round-robin picker: searches (last+1) mod N upward and
// returns the first requester that is asking.
module rr_pick
  import a2d_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int PW     = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      last,
  output logic               vld,
  output logic [PW-1:0]      idx
);

  int            cand;
  logic [PW-1:0] cand_idx;

  // Walk candidates farthest-first so the nearest one after last wins.
  always_comb begin
    vld      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(last) + k) % NUM_REQ;
      cand_idx = PW'(cand);
      if (req[cand_idx]) begin
        vld = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/a2d_arb.sv
// Arbiter sharing one A2D converter among NUM_REQ requesters.
// Handshake: a requester holds req high until it sees a one-cycle rdy
// (result valid in rslt) or tmo (conversion aborted) pulse addressed to it;
// toward the converter, strt_cnv is a one-cycle start and cnv_cmplt a
// one-cycle completion qualified only while waiting.
module a2d_arb
  import a2d_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]   rdy,
  output logic [NUM_REQ-1:0]   tmo,
  output rslt_t                rslt,
  output logic                 busy,
  output logic [2:0]           chnnl,
  output logic                 strt_cnv,
  input  logic                 cnv_cmplt,
  input  rslt_t                res,
  output state_t               state_dbg
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0]      TMO_LAST = CW'(TMO_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  state_t        state;
  logic [PW-1:0] owner;
  logic [PW-1:0] last;
  logic [CW-1:0] cnt;
  logic          pick_vld;
  logic [PW-1:0] pick_idx;

  assign state_dbg = state;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req),
    .last (last),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  // Arbitration FSM with all outputs registered. The counter reads 0 during
  // START and then counts cycles since strt_cnv, so the abort pulse lands
  // TMO_CYCLES cycles after the start pulse. No grant is made in the cycle
  // a rdy/tmo pulse is out, giving the finished owner time to drop req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= PW'(NUM_REQ - 1);
      owner    <= '0;
      cnt      <= '0;
      chnnl    <= '0;
      rslt     <= '0;
      rdy      <= '0;
      tmo      <= '0;
      strt_cnv <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rdy      <= '0;
      tmo      <= '0;
      strt_cnv <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld && !(|rdy) && !(|tmo)) begin
            owner    <= pick_idx;
            chnnl    <= req_chnnl[3*pick_idx +: 3];
            cnt      <= '0;
            strt_cnv <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= cnt + CW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnv_cmplt) begin
            rslt  <= res;
            rdy   <= ONE << owner;
            last  <= owner;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt >= TMO_LAST) begin
            tmo   <= ONE << owner;
            last  <= owner;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_arb.sv
// Directed bench for a2d_arb: instance a uses the default timeout, instance
// b a short timeout of 8 cycles. Expected channels/results are queued when
// stimulus is driven and popped when the DUT responds.
module tb_a2d_arb;
  import a2d_arb_pkg::*;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [3*N-1:0]   req_chnnl = '0;
  logic             cc_a = 1'b0;
  logic             cc_b = 1'b0;
  logic [11:0]      res = '0;

  logic [N-1:0]     rdy_a, tmo_a, rdy_b, tmo_b;
  logic [11:0]      rslt_a, rslt_b;
  logic             busy_a, busy_b, strt_a, strt_b;
  logic [2:0]       ch_a, ch_b;
  state_t           st_a, st_b;

  int               checks = 0;
  int               errors = 0;
  logic [15:0]      exp_q[$];

  a2d_arb #(.NUM_REQ(N)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl),
    .rdy(rdy_a), .tmo(tmo_a), .rslt(rslt_a), .busy(busy_a), .chnnl(ch_a),
    .strt_cnv(strt_a), .cnv_cmplt(cc_a), .res(res), .state_dbg(st_a)
  );

  a2d_arb #(.NUM_REQ(N), .TMO_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl),
    .rdy(rdy_b), .tmo(tmo_b), .rslt(rslt_b), .busy(busy_b), .chnnl(ch_b),
    .strt_cnv(strt_b), .cnv_cmplt(cc_b), .res(res), .state_dbg(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    req   = '0;
    cc_a  = 1'b0;
    cc_b  = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rdy"},   16'(rdy_a),    16'd0);
    check({tag, "_tmo"},   16'(tmo_a),    16'd0);
    check({tag, "_strt"},  16'(strt_a),   16'd0);
    check({tag, "_busy"},  16'(busy_a),   16'd0);
    check({tag, "_chnnl"}, 16'(ch_a),     16'd0);
    check({tag, "_rslt"},  16'(rslt_a),   16'd0);
    check({tag, "_state"}, 16'(st_a),     16'(IDLE));
  endtask

  // Bounded wait for a start pulse on instance a (sel=0) or b (sel=1).
  task automatic wait_strt(input bit sel, input string tag);
    int t;
    t = 0;
    while (((sel ? strt_b : strt_a) !== 1'b1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_strt"}, 16'(sel ? strt_b : strt_a), 16'd1);
  endtask

  initial begin
    logic [11:0] val;
    logic [N-1:0] seen;
    int owner;

    // reset state
    step(3);
    reset_checks("reset");
    rst_n = 1'b1;
    step(1);

    // single request, channel 5, completion 20 cycles after start
    req_chnnl = {3'd0, 3'd0, 3'd5};
    req = 3'b001;
    exp_q.push_back(16'd5);
    step(1);
    check("s1_strt_cycle1", 16'(strt_a), 16'd1);
    check("s1_chnnl", 16'(ch_a), exp_q.pop_front());
    check("s1_busy", 16'(busy_a), 16'd1);
    step(1);
    check("s1_strt_pulse", 16'(strt_a), 16'd0);
    req = 3'b000;                       // dropping req mid-WAIT must not abort
    step(19);
    cc_a = 1'b1;
    res  = 12'hA5C;
    exp_q.push_back(16'h0A5C);
    step(1);
    cc_a = 1'b0;
    res  = 12'h000;
    check("s1_rdy", 16'(rdy_a), 16'b001);
    check("s1_rslt", 16'(rslt_a), exp_q.pop_front());
    check("s1_tmo", 16'(tmo_a), 16'd0);
    step(1);
    check("s1_rdy_pulse", 16'(rdy_a), 16'd0);
    check("s1_idle_busy", 16'(busy_a), 16'd0);

    // completion while idle is ignored
    cc_a = 1'b1;
    res  = 12'h123;
    step(1);
    cc_a = 1'b0;
    step(1);
    check("idle_cc_rdy", 16'(rdy_a), 16'd0);
    check("idle_cc_rslt", 16'(rslt_a), 16'h0A5C);

    // contention: all three held, grants 0,1,2,0
    do_reset();
    req_chnnl = {3'd3, 3'd2, 3'd1};
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      owner = g % 3;
      exp_q.push_back(16'(owner + 1));
      wait_strt(1'b0, $sformatf("cont%0d", g));
      check($sformatf("cont%0d_chnnl", g), 16'(ch_a), exp_q.pop_front());
      step(3);
      val  = 12'($urandom_range(1, 4095));
      cc_a = 1'b1;
      res  = val;
      exp_q.push_back(16'(val));
      step(1);
      cc_a = 1'b0;
      check($sformatf("cont%0d_rdy", g), 16'(rdy_a), 16'(3'b001 << owner));
      check($sformatf("cont%0d_rslt", g), 16'(rslt_a), exp_q.pop_front());
      check($sformatf("cont%0d_tmo", g), 16'(tmo_a), 16'd0);
    end
    req = 3'b000;

    // reset in the middle of a conversion owned by requester 1
    step(2);
    req = 3'b010;
    exp_q.push_back(16'd2);
    wait_strt(1'b0, "mid");
    check("mid_chnnl", 16'(ch_a), exp_q.pop_front());
    step(4);
    rst_n = 1'b0;
    req   = 3'b000;
    seen  = '0;
    step(1);
    reset_checks("mid_rst");
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen = seen | rdy_a | tmo_a;
    end
    check("mid_no_pulse", 16'(seen), 16'd0);
    req = 3'b011;
    exp_q.push_back(16'd1);
    wait_strt(1'b0, "mid_next");
    check("mid_next_chnnl", 16'(ch_a), exp_q.pop_front());
    step(2);
    cc_a = 1'b1;
    res  = 12'h0F0;
    step(1);
    cc_a = 1'b0;
    req  = 3'b000;
    check("mid_next_rdy", 16'(rdy_a), 16'b001);

    // timeout on instance b (TMO_CYCLES = 8)
    do_reset();
    res = 12'h777;
    req_chnnl = {3'd6, 3'd4, 3'd5};
    req = 3'b011;
    exp_q.push_back(16'd5);
    wait_strt(1'b1, "tmo");
    check("tmo_chnnl", 16'(ch_b), exp_q.pop_front());
    seen = '0;
    for (int k = 1; k < 8; k++) begin
      step(1);
      seen = seen | rdy_b | tmo_b;
    end
    check("tmo_early", 16'(seen), 16'd0);
    step(1);
    check("tmo_pulse", 16'(tmo_b), 16'b001);
    check("tmo_rdy", 16'(rdy_b), 16'd0);
    check("tmo_rslt", 16'(rslt_b), 16'd0);
    req = 3'b010;
    exp_q.push_back(16'd4);
    wait_strt(1'b1, "tmo_next");
    check("tmo_next_chnnl", 16'(ch_b), exp_q.pop_front());

    // completion in the same cycle the timeout expires
    step(7);
    cc_b = 1'b1;
    res  = 12'hBEE;
    exp_q.push_back(16'h0BEE);
    step(1);
    cc_b = 1'b0;
    req  = 3'b000;
    check("sim_rdy", 16'(rdy_b), 16'b010);
    check("sim_tmo", 16'(tmo_b), 16'd0);
    check("sim_rslt", 16'(rslt_b), exp_q.pop_front());
    step(2);
    check("sim_after", 16'({rdy_b, tmo_b}), 16'd0);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
